// File: rtl/serial_adder_ctrl_pkg.sv
// Shared FSM encodings and default width for the bit-serial adder family.
// Combinational constants only: no latency or flow control.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/halfadder.sv
// One-bit half adder cell.
// Purely combinational; no backpressure.
module halfadder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_fa_slice.sv
// One-bit full adder built from two half adders plus an OR.
// Purely combinational; no backpressure.
module serial_fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic prop;
    logic gen_ab;
    logic gen_pc;

    halfadder u_ha_ab (
        .a     (a),
        .b     (b),
        .sum   (prop),
        .carry (gen_ab)
    );

    halfadder u_ha_pc (
        .a     (prop),
        .b     (cin),
        .sum   (sum),
        .carry (gen_pc)
    );

    assign cout = gen_ab | gen_pc;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full-adder slice reused LSB-first over WIDTH cycles.
// done pulses WIDTH cycles after an accepted start; start is ignored (not queued) while busy.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             slice_sum;
    logic             slice_carry;
    logic             last_bit;

    serial_fa_slice u_slice (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_carry)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == RUN) || (state == DONE);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: the +1 enters through the initial carry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a    <= a;
                        op_b    <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt     <= '0;
                        sum     <= '0;
                    end
                end
                RUN: begin
                    sum     <= {slice_sum, sum[WIDTH-1:1]};
                    op_a    <= {1'b0, op_a[WIDTH-1:1]};
                    op_b    <= {1'b0, op_b[WIDTH-1:1]};
                    carry_q <= slice_carry;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_bit) carry_out <= slice_carry;
                end
                default: ;
            endcase
        end
    end

endmodule
